// File: rtl/firebird7_in_gate1_ijtag_pkg.sv
// Shared types for the gate1 IJTAG Capture-Shift-Update sequencer.
package firebird7_in_gate1_ijtag_pkg;

  localparam int DEFAULT_MAX_LEN = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SHIFT   = 3'd2,
    UPDATE  = 3'd3,
    RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/firebird7_in_gate1_ijtag_shifter.sv
// Parallel-load right-shift register feeding si, plus a bit-indexed capture
// register collecting so samples.
module firebird7_in_gate1_ijtag_shifter #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic               shift_i,
  input  logic [MAX_LEN-1:0] data_i,
  input  logic               so_i,
  input  logic [LEN_W-1:0]   idx_i,
  output logic               si_o,
  output logic [MAX_LEN-1:0] cap_o
);

  logic [MAX_LEN-1:0] sr_q, sr_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (clear_i) begin
      sr_d = '0;
    end else if (shift_i) begin
      sr_d = sr_q >> 1;
    end
  end

  // Each capture bit only listens when the shift index points at it, so bits
  // beyond the scan length stay at the zero they were cleared to on load.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_cap
    assign cap_d[gi] = (load_i || clear_i)                    ? 1'b0 :
                       (shift_i && (idx_i == LEN_W'(gi)))      ? so_i :
                                                                 cap_q[gi];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cap_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cap_q <= cap_d;
    end
  end

  assign si_o  = sr_q[0];
  assign cap_o = cap_q;

endmodule

// File: rtl/firebird7_in_gate1_ijtag_csu_sequencer.sv
// Host-side IJTAG controller: one command runs one Capture-Shift-Update
// sequence on the driven segment and returns the scanned-out bits.
module firebird7_in_gate1_ijtag_csu_sequencer
  import firebird7_in_gate1_ijtag_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               ijtag_tck,
  input  logic               ijtag_reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               ijtag_sel,
  output logic               ijtag_ce,
  output logic               ijtag_se,
  output logic               ijtag_ue,
  output logic               ijtag_si,
  input  logic               ijtag_so
);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               sh_load, sh_clear, sh_shift;
  logic               sh_si;
  logic [MAX_LEN-1:0] sh_cap;
  logic               len_bad;

  assign len_bad = cmd_len > LEN_W'(MAX_LEN);

  firebird7_in_gate1_ijtag_shifter #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_shifter (
    .clk_i  (ijtag_tck),
    .rst_i  (ijtag_reset),
    .load_i (sh_load),
    .clear_i(sh_clear),
    .shift_i(sh_shift),
    .data_i (cmd_data),
    .so_i   (ijtag_so),
    .idx_i  (cnt_q),
    .si_o   (sh_si),
    .cap_o  (sh_cap)
  );

  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    sh_load  = 1'b0;
    sh_clear = 1'b0;
    sh_shift = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (len_bad) begin
            err_d    = 1'b1;
            sh_clear = 1'b1;
            state_d  = RESP;
          end else begin
            err_d   = 1'b0;
            len_d   = cmd_len;
            cnt_d   = '0;
            sh_load = 1'b1;
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE: state_d = (len_q == '0) ? UPDATE : SHIFT;
      SHIFT: begin
        // len_q is at least 1 here; cnt tops out at MAX_LEN which LEN_W holds
        sh_shift = 1'b1;
        cnt_d    = cnt_q + LEN_W'(1);
        if (cnt_q == len_q - LEN_W'(1)) begin
          state_d = UPDATE;
        end
      end
      UPDATE: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    ijtag_sel = 1'b0;
    ijtag_ce  = 1'b0;
    ijtag_se  = 1'b0;
    ijtag_ue  = 1'b0;
    ijtag_si  = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      CAPTURE: begin
        ijtag_sel = 1'b1;
        ijtag_ce  = 1'b1;
      end
      SHIFT: begin
        ijtag_sel = 1'b1;
        ijtag_se  = 1'b1;
        ijtag_si  = sh_si;
      end
      UPDATE: begin
        ijtag_sel = 1'b1;
        ijtag_ue  = 1'b1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_data  = sh_cap;
      end
      default: busy = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_firebird7_in_gate1_ijtag_csu_sequencer.sv
// Random commands against an 8-bit loopback TDR; responses are scored against
// a stream model (capture value followed by shift-in data).
module tb_firebird7_in_gate1_ijtag_csu_sequencer;

  localparam int MAX_LEN = 64;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int SEG_N   = 8;

  logic               ijtag_tck   = 1'b0;
  logic               ijtag_reset = 1'b0;
  logic               cmd_valid   = 1'b0;
  logic [LEN_W-1:0]   cmd_len     = '0;
  logic [MAX_LEN-1:0] cmd_data    = '0;
  logic               rsp_ready   = 1'b0;
  logic               ijtag_so    = 1'b0;
  logic               cmd_ready, rsp_valid, rsp_err, busy;
  logic               ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si;
  logic [MAX_LEN-1:0] rsp_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [MAX_LEN-1:0] data;
    logic               err;
    int                 len;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference state: what the loopback TDR's update latch should hold.
  logic [SEG_N-1:0] upd_m = 8'h3C;

  // Segment under test: capture from update latch, shift toward so.
  logic [SEG_N-1:0] seg_q = '0;
  logic [SEG_N-1:0] upd_q = 8'h3C;

  firebird7_in_gate1_ijtag_csu_sequencer dut (
    .ijtag_tck  (ijtag_tck),
    .ijtag_reset(ijtag_reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .ijtag_sel  (ijtag_sel),
    .ijtag_ce   (ijtag_ce),
    .ijtag_se   (ijtag_se),
    .ijtag_ue   (ijtag_ue),
    .ijtag_si   (ijtag_si),
    .ijtag_so   (ijtag_so)
  );

  always #5 ijtag_tck = ~ijtag_tck;

  always @(posedge ijtag_tck) begin
    if (ijtag_sel && ijtag_ce) seg_q <= upd_q;
    else if (ijtag_sel && ijtag_se) seg_q <= {ijtag_si, seg_q[SEG_N-1:1]};
    if (ijtag_sel && ijtag_ue) upd_q <= seg_q;
  end

  always @(negedge ijtag_tck) ijtag_so <= seg_q[0];

  task automatic chk(input string name, input logic [MAX_LEN-1:0] act,
                     input logic [MAX_LEN-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard monitor: pops one expectation per response handshake.
  always @(negedge ijtag_tck) begin
    if (!ijtag_reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_rsp", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("txn len=%0d err=%b data=%h expected=%h", mon_e.len, rsp_err,
                 rsp_data, mon_e.data);
        chk("rsp_data", rsp_data, mon_e.data);
        chk("rsp_err", {63'd0, rsp_err}, {63'd0, mon_e.err});
      end
    end
  end

  task automatic run_cmd(input int len, input logic [MAX_LEN-1:0] data,
                         input int hold, input int abort_at);
    int c, ce_n, ce_c, se_n, ue_n, ue_c, sel_n, rv_c, hcnt, oh_bad, stab_bad;
    bit err, hs;
    logic [MAX_LEN-1:0] si_seq, mask, held, exp_d;
    logic [MAX_LEN+SEG_N-1:0] s;
    exp_t e;
    err   = (len > MAX_LEN);
    mask  = (len >= MAX_LEN) ? '1 : ((MAX_LEN'(1) << len) - MAX_LEN'(1));
    s     = {data, upd_m};
    exp_d = s[MAX_LEN-1:0] & mask;
    ce_n = 0; ce_c = -1; se_n = 0; ue_n = 0; ue_c = -1; sel_n = 0; rv_c = -1;
    hcnt = 0; oh_bad = 0; stab_bad = 0; si_seq = '0; held = '0; hs = 0;

    c = 0;
    @(negedge ijtag_tck);
    while (!cmd_ready && c < 200) begin
      @(negedge ijtag_tck);
      c++;
    end
    if (!cmd_ready) begin
      chk("ready_wait_timeout", 0, 1);
      return;
    end
    @(posedge ijtag_tck);
    #1;
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    cmd_data  = data;
    rsp_ready = 1'b0;
    if (abort_at < 0) begin
      e.data = err ? '0 : exp_d;
      e.err  = err;
      e.len  = len;
      exp_q.push_back(e);
      if (!err) upd_m = SEG_N'(s >> len);
    end
    @(negedge ijtag_tck);

    c = 0;
    while (!hs && c < 400) begin
      @(posedge ijtag_tck);
      #1;
      if (rv_c >= 0 && hcnt >= hold) begin
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
      end else begin
        if (rv_c >= 0) hcnt++;
        rsp_ready = (rv_c < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        cmd_valid = rsp_ready ? 1'b0 : 1'($urandom_range(0, 1));
        cmd_len   = LEN_W'($urandom);
        cmd_data  = {$urandom, $urandom};
      end
      @(negedge ijtag_tck);
      c++;
      if (ijtag_ce) begin
        ce_n++;
        if (ce_c < 0) ce_c = c;
      end
      if (ijtag_se) begin
        si_seq = si_seq | (MAX_LEN'(ijtag_si) << se_n);
        se_n++;
      end
      if (ijtag_ue) begin
        ue_n++;
        ue_c = c;
      end
      if (ijtag_sel) sel_n++;
      if ((int'(ijtag_ce) + int'(ijtag_se) + int'(ijtag_ue)) > 1) oh_bad++;
      if ((ijtag_ce || ijtag_se || ijtag_ue) && !ijtag_sel) oh_bad++;
      if (rsp_valid) begin
        if (rv_c < 0) begin
          rv_c = c;
          held = rsp_data;
        end
        if (rsp_data !== held || cmd_ready || !busy || ijtag_sel) stab_bad++;
        if (rsp_ready) hs = 1;
      end
      if (abort_at >= 0 && se_n == abort_at) begin
        @(posedge ijtag_tck);
        #1;
        cmd_valid   = 1'b0;
        rsp_ready   = 1'b0;
        ijtag_reset = 1'b1;
        #1;
        chk("abort_ctrl", {55'd0, ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si,
                           rsp_valid, rsp_err, busy, cmd_ready}, 64'd1);
        chk("abort_data", rsp_data, '0);
        @(negedge ijtag_tck);
        chk("abort_hold_ready", {63'd0, cmd_ready}, 64'd1);
        #1;
        ijtag_reset = 1'b0;
        return;
      end
    end
    if (!hs) begin
      chk("rsp_handshake_timeout", 0, 1);
      return;
    end

    if (err) begin
      chk("err_rsp_cycle", rv_c, 1);
      chk("err_no_sel", sel_n, 0);
      chk("err_no_pulse", ce_n + se_n + ue_n, 0);
    end else begin
      chk("ce_cycle", ce_c, 1);
      chk("ce_count", ce_n, 1);
      chk("se_count", se_n, len);
      chk("ue_cycle", ue_c, len + 2);
      chk("ue_count", ue_n, 1);
      chk("rsp_cycle", rv_c, len + 3);
      chk("sel_count", sel_n, len + 2);
      chk("si_sequence", si_seq, data & mask);
      chk("strobe_exclusive", oh_bad, 0);
    end
    chk("rsp_stable", stab_bad, 0);

    @(posedge ijtag_tck);
    #1;
    rsp_ready = 1'b0;
    @(negedge ijtag_tck);
    chk("post_handshake", {61'd0, rsp_valid, cmd_ready, busy}, 64'd2);
  endtask

  initial begin
    #1;
    ijtag_reset = 1'b1;
    repeat (3) @(negedge ijtag_tck);
    chk("reset_ctrl", {55'd0, ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si,
                       rsp_valid, rsp_err, busy, cmd_ready}, 64'd1);
    chk("reset_data", rsp_data, '0);
    @(posedge ijtag_tck);
    #1;
    ijtag_reset = 1'b0;

    run_cmd(8, 64'hA5, 0, -1);
    run_cmd(0, {$urandom, $urandom}, 1, -1);
    run_cmd(MAX_LEN + 1, {$urandom, $urandom}, 0, -1);
    run_cmd(1, 64'h1, 5, -1);
    run_cmd(2, 64'h0, 0, -1);
    run_cmd(MAX_LEN, {$urandom, $urandom}, 2, -1);
    run_cmd(16, {$urandom, $urandom}, 0, 7);
    run_cmd(8, {$urandom, $urandom}, 0, -1);
    run_cmd(127, {$urandom, $urandom}, 3, -1);
    for (int i = 0; i < 40; i++) begin
      int r, l;
      r = $urandom_range(0, 9);
      if (r == 0) l = $urandom_range(MAX_LEN + 1, 127);
      else if (r == 1) l = 0;
      else if (r == 2) l = MAX_LEN;
      else l = $urandom_range(1, MAX_LEN);
      run_cmd(l, {$urandom, $urandom}, $urandom_range(0, 5), -1);
    end

    repeat (5) @(negedge ijtag_tck);
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
